// File: rtl/rmi_spi_slave_engine.sv
// SPI slave shift engine in the i_sclk domain: configurable word width, CPOL/CPHA and bit
// order, a one-word TX holding register with FILL on underrun, and a per-frame word counter.
module rmi_spi_slave_engine #(
   parameter int                DATA_W = 8,
   parameter bit                CPOL   = 1'b0,
   parameter bit                CPHA   = 1'b0,
   parameter bit                LSBF   = 1'b0,
   parameter int                CNT_W  = 8,
   parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
   input  logic              i_sclk,
   input  logic              spi_rst,
   input  logic              i_csn,
   input  logic              i_mosi,
   output logic              o_miso,
   output logic              o_miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_vld,
   output logic              tx_rdy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_vld,
   output logic [CNT_W-1:0]  rx_cnt,
   output logic              tx_underrun
);

   localparam int              BC_W       = $clog2(DATA_W);
   localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(DATA_W - 1);
   localparam bit              SAMPLE_INV = CPOL ^ CPHA;

   logic              sample_clk;
   logic              launch_clk;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic [DATA_W-1:0] tx_shreg;
   logic [DATA_W-1:0] rx_shreg;
   logic [BC_W-1:0]   bit_cnt;
   logic              miso_q;
   logic              past_first;
   logic [DATA_W-1:0] slot_word;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_next;
   logic              slot_first;
   logic              shreg_top;
   logic              word_start;
   logic              word_end;

   // Rising edge of sample_clk is the sample edge for every CPOL/CPHA combination.
   assign sample_clk = i_sclk ^ SAMPLE_INV;
   assign launch_clk = ~sample_clk;

   always_comb begin
      slot_word  = hold_full ? hold : FILL;
      word_start = ~i_csn && (bit_cnt == '0);
      word_end   = (bit_cnt == LAST_BIT);
      slot_first = 1'b0;
      shreg_top  = 1'b0;
      rx_next    = '0;
      tx_next    = '0;
      if (LSBF) begin
         slot_first = slot_word[0];
         shreg_top  = tx_shreg[0];
         rx_next    = {i_mosi, rx_shreg[DATA_W-1:1]};
         tx_next    = (word_start ? slot_word : tx_shreg) >> 1;
      end else begin
         slot_first = slot_word[DATA_W-1];
         shreg_top  = tx_shreg[DATA_W-1];
         rx_next    = {rx_shreg[DATA_W-2:0], i_mosi};
         tx_next    = (word_start ? slot_word : tx_shreg) << 1;
      end
   end

   // Holding register, received word and underrun flag survive chip-select deassertion.
   always_ff @(posedge sample_clk or posedge spi_rst) begin
      if (spi_rst) begin
         hold        <= '0;
         hold_full   <= 1'b0;
         rx_data     <= '0;
         tx_underrun <= 1'b0;
      end else begin
         if (word_start && !hold_full) begin
            tx_underrun <= 1'b1;
         end
         if (tx_vld && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end else if (word_start) begin
            hold_full <= 1'b0;
         end
         if (!i_csn && word_end) begin
            rx_data <= rx_next;
         end
      end
   end

   always_ff @(posedge sample_clk or posedge spi_rst or posedge i_csn) begin
      if (spi_rst || i_csn) begin
         bit_cnt  <= '0;
         rx_shreg <= '0;
         tx_shreg <= '0;
         rx_vld   <= 1'b0;
         rx_cnt   <= '0;
      end else begin
         rx_shreg <= rx_next;
         tx_shreg <= tx_next;
         rx_vld   <= word_end;
         if (word_end) begin
            bit_cnt <= '0;
            if (rx_cnt != '1) begin
               rx_cnt <= rx_cnt + CNT_W'(1);
            end
         end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
         end
      end
   end

   // After the last sample of a word bit_cnt is 0, so the next slot's first bit comes from hold/FILL.
   always_ff @(posedge launch_clk or posedge spi_rst or posedge i_csn) begin
      if (spi_rst || i_csn) begin
         miso_q     <= 1'b0;
         past_first <= 1'b0;
      end else begin
         miso_q     <= (bit_cnt == '0) ? slot_first : shreg_top;
         past_first <= 1'b1;
      end
   end

   assign tx_rdy    = ~hold_full;
   assign o_miso_oe = ~i_csn;
   assign o_miso    = i_csn ? 1'b0 : ((!CPHA && !past_first) ? slot_first : miso_q);

endmodule

// File: tb/tb_rmi_spi_slave_engine.sv
// Bench for rmi_spi_slave_engine: two instances (mode 0 MSB-first 8-bit, mode 3 LSB-first 16-bit)
// driven by a bit-level SPI master and compared against a word/slot-level behavioural model.
module tb_rmi_spi_slave_engine;

   int dw     [2] = '{8, 16};
   bit cpha_a [2] = '{1'b0, 1'b1};
   bit cpol_a [2] = '{1'b0, 1'b1};
   bit lsbf_a [2] = '{1'b0, 1'b1};
   int cmax   [2] = '{3, 255};

   logic        sclk [2];
   logic        rst [2];
   logic        csn [2];
   logic        mosi [2];
   logic        tx_vld [2];
   logic [31:0] txd [2];
   logic        miso [2];
   logic        oe [2];
   logic        rdy [2];
   logic        vld [2];
   logic        und [2];
   logic [7:0]  rxd0;
   logic [15:0] rxd1;
   logic [1:0]  cnt0;
   logic [7:0]  cnt1;

   rmi_spi_slave_engine #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSBF(1'b0), .CNT_W(2)) dut0 (
      .i_sclk(sclk[0]), .spi_rst(rst[0]), .i_csn(csn[0]), .i_mosi(mosi[0]),
      .o_miso(miso[0]), .o_miso_oe(oe[0]), .tx_data(txd[0][7:0]), .tx_vld(tx_vld[0]),
      .tx_rdy(rdy[0]), .rx_data(rxd0), .rx_vld(vld[0]), .rx_cnt(cnt0), .tx_underrun(und[0]));

   rmi_spi_slave_engine #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .LSBF(1'b1), .CNT_W(8)) dut1 (
      .i_sclk(sclk[1]), .spi_rst(rst[1]), .i_csn(csn[1]), .i_mosi(mosi[1]),
      .o_miso(miso[1]), .o_miso_oe(oe[1]), .tx_data(txd[1][15:0]), .tx_vld(tx_vld[1]),
      .tx_rdy(rdy[1]), .rx_data(rxd1), .rx_vld(vld[1]), .rx_cnt(cnt1), .tx_underrun(und[1]));

   // Behavioural model state: hold contents, sticky flag, position within the current word.
   bit          m_full [2];
   bit          m_under [2];
   bit          m_vld [2];
   logic [31:0] m_hold [2];
   logic [31:0] m_rxd [2];
   logic [31:0] m_acc [2];
   int          m_bit [2];
   int          m_cnt [2];

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] got_q[$];
   int          cnt_hist[$];
   int          vld_seen;
   logic [31:0] mo_words[$];

   function automatic logic [31:0] mask_of(int d);
      return (32'd1 << dw[d]) - 32'd1;
   endfunction

   function automatic logic [31:0] rxd_of(int d);
      return (d == 0) ? {24'd0, rxd0} : {16'd0, rxd1};
   endfunction

   function automatic int cnt_of(int d);
      return (d == 0) ? int'(cnt0) : int'(cnt1);
   endfunction

   task automatic check(int d, string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL d%0d_%s: got 0x%0h, expected 0x%0h", d, name, act, exp);
   endtask

   task automatic model_sample(int d, bit mo, bit load, logic [31:0] ld);
      bit rdy_pre;
      int pos;
      rdy_pre = !m_full[d];
      pos = lsbf_a[d] ? m_bit[d] : dw[d] - 1 - m_bit[d];
      if (m_bit[d] == 0) begin
         if (m_full[d]) m_full[d] = 1'b0;
         else m_under[d] = 1'b1;
      end
      if (load && rdy_pre) begin
         m_hold[d] = ld & mask_of(d);
         m_full[d] = 1'b1;
      end
      m_acc[d][pos] = mo;
      if (m_bit[d] == dw[d] - 1) begin
         m_rxd[d] = m_acc[d];
         m_acc[d] = '0;
         m_vld[d] = 1'b1;
         if (m_cnt[d] < cmax[d]) m_cnt[d]++;
         m_bit[d] = 0;
      end else begin
         m_vld[d] = 1'b0;
         m_bit[d]++;
      end
   endtask

   task automatic model_frame_clear(int d);
      m_bit[d] = 0;
      m_cnt[d] = 0;
      m_vld[d] = 1'b0;
      m_acc[d] = '0;
   endtask

   task automatic post_checks(int d);
      check(d, "rx_vld", vld[d], m_vld[d]);
      check(d, "rx_cnt", cnt_of(d), m_cnt[d]);
      check(d, "rx_data", rxd_of(d), m_rxd[d]);
      check(d, "tx_underrun", und[d], m_under[d]);
      check(d, "tx_rdy_post", rdy[d], !m_full[d]);
      if (vld[d] === 1'b1) vld_seen++;
      if (m_vld[d]) cnt_hist.push_back(cnt_of(d));
   endtask

   task automatic pre_checks(int d, bit exp_bit);
      check(d, "miso", miso[d], exp_bit);
      check(d, "miso_oe", oe[d], 1'b1);
      check(d, "tx_rdy_pre", rdy[d], !m_full[d]);
   endtask

   task automatic do_bit(int d, bit mo, bit exp_bit, bit load, logic [31:0] ld, output logic mi);
      if (!cpha_a[d]) begin
         #1 mosi[d] = mo; tx_vld[d] = load; txd[d] = ld;
         #2 mi = miso[d]; pre_checks(d, exp_bit);
         #2 sclk[d] = ~sclk[d];
         #1 model_sample(d, mo, load, ld); tx_vld[d] = 1'b0; post_checks(d);
         #4 sclk[d] = ~sclk[d];
      end else begin
         sclk[d] = ~sclk[d];
         #1 mosi[d] = mo; tx_vld[d] = load; txd[d] = ld;
         #2 mi = miso[d]; pre_checks(d, exp_bit);
         #2 sclk[d] = ~sclk[d];
         #1 model_sample(d, mo, load, ld); tx_vld[d] = 1'b0; post_checks(d);
         #4;
      end
   endtask

   task automatic idle_checks(int d);
      check(d, "idle_miso", miso[d], 1'b0);
      check(d, "idle_oe", oe[d], 1'b0);
      check(d, "idle_vld", vld[d], 1'b0);
      check(d, "idle_cnt", cnt_of(d), 0);
      check(d, "idle_rdy", rdy[d], !m_full[d]);
      check(d, "idle_underrun", und[d], m_under[d]);
   endtask

   // One full SCK period with chip select high: exactly one sample edge, so at most one load.
   task automatic idle_load(int d, logic [31:0] val);
      tx_vld[d] = 1'b1; txd[d] = val;
      #2 sclk[d] = ~sclk[d];
      #5 sclk[d] = ~sclk[d];
      #3 tx_vld[d] = 1'b0;
      if (!m_full[d]) begin
         m_hold[d] = val & mask_of(d);
         m_full[d] = 1'b1;
      end
      #1 check(d, "load_rdy", rdy[d], !m_full[d]);
   endtask

   task automatic frame(int d, int nbits, int load_bit, logic [31:0] load_val, int pct, bit do_rst);
      logic [31:0] exp_tx, w_got, word, ld;
      bit          mo, eb, load;
      logic        mi;
      int          b, pos;
      while (mo_words.size() * dw[d] < nbits) mo_words.push_back($urandom & mask_of(d));
      got_q.delete(); cnt_hist.delete(); vld_seen = 0;
      exp_tx = '0; w_got = '0;
      csn[d] = 1'b0;
      #5;
      for (int i = 0; i < nbits; i++) begin
         b = m_bit[d];
         pos = lsbf_a[d] ? b : dw[d] - 1 - b;
         if (b == 0) exp_tx = m_full[d] ? m_hold[d] : mask_of(d);
         word = mo_words[i / dw[d]];
         mo = word[pos];
         eb = exp_tx[pos];
         load = (i == load_bit) || ($urandom_range(99) < pct);
         ld = (i == load_bit) ? load_val : ($urandom & mask_of(d));
         do_bit(d, mo, eb, load, ld, mi);
         w_got[pos] = mi;
         if (b == dw[d] - 1) begin
            got_q.push_back(w_got);
            w_got = '0;
         end
      end
      if (do_rst) begin
         rst[d] = 1'b1;
         #1;
         check(d, "rst_rdy", rdy[d], 1'b1);
         check(d, "rst_rxd", rxd_of(d), 0);
         check(d, "rst_underrun", und[d], 1'b0);
         check(d, "rst_cnt", cnt_of(d), 0);
         m_full[d] = 1'b0; m_under[d] = 1'b0; m_hold[d] = '0; m_rxd[d] = '0;
         model_frame_clear(d);
         #2 rst[d] = 1'b0;
      end
      #5 csn[d] = 1'b1;
      model_frame_clear(d);
      mo_words.delete();
      #5 idle_checks(d);
   endtask

   initial begin
      int exp6 [6] = '{1, 2, 3, 3, 3, 3};
      int nb;
      for (int d = 0; d < 2; d++) begin
         sclk[d] = cpol_a[d]; rst[d] = 1'b1; csn[d] = 1'b1; mosi[d] = 1'b0;
         tx_vld[d] = 1'b0; txd[d] = '0;
         m_full[d] = 1'b0; m_under[d] = 1'b0; m_hold[d] = '0; m_rxd[d] = '0;
         model_frame_clear(d);
      end
      #10;
      for (int d = 0; d < 2; d++) begin
         check(d, "reset_rdy", rdy[d], 1'b1);
         check(d, "reset_rxd", rxd_of(d), 0);
         check(d, "reset_vld", vld[d], 1'b0);
         check(d, "reset_cnt", cnt_of(d), 0);
         check(d, "reset_underrun", und[d], 1'b0);
         check(d, "reset_oe", oe[d], 1'b0);
         rst[d] = 1'b0;
      end
      #10;

      // Mode 0, MSB first: A5 out, 3C in.
      idle_load(0, 32'hA5);
      mo_words.push_back(32'h3C);
      frame(0, 8, -1, 0, 0, 0);
      check(0, "t1_miso_word", got_q[0], 32'hA5);
      check(0, "t1_rxd", rxd_of(0), 32'h3C);
      check(0, "t1_vld_pulses", vld_seen, 1);
      check(0, "t1_cnt", cnt_hist[0], 1);
      check(0, "t1_underrun", und[0], 1'b0);

      // Mode 3, LSB first, 16 bit.
      idle_load(1, 32'h1234);
      mo_words.push_back(32'hBEEF);
      frame(1, 16, -1, 0, 0, 0);
      check(1, "t2_miso_word", got_q[0], 32'h1234);
      check(1, "t2_rxd", rxd_of(1), 32'hBEEF);
      check(1, "t2_vld_pulses", vld_seen, 1);

      // Underrun: only the first word supplied.
      idle_load(0, 32'h55);
      frame(0, 24, -1, 0, 0, 0);
      check(0, "t3_w0", got_q[0], 32'h55);
      check(0, "t3_w1", got_q[1], 32'hFF);
      check(0, "t3_w2", got_q[2], 32'hFF);
      check(0, "t3_underrun_sticky", und[0], 1'b1);

      // Late load: first seen at the bit-0 sample edge of word 1, so it rides in word 2.
      idle_load(0, 32'h11);
      frame(0, 24, 8, 32'h77, 0, 0);
      check(0, "t4_w0", got_q[0], 32'h11);
      check(0, "t4_w1", got_q[1], 32'hFF);
      check(0, "t4_w2", got_q[2], 32'h77);

      // Abort after 5 bits, then a clean frame, then reset mid-word.
      idle_load(0, 32'hC3);
      frame(0, 5, -1, 0, 0, 0);
      check(0, "t5_abort_vld", vld_seen, 0);
      mo_words.push_back(32'h5A);
      frame(0, 8, -1, 0, 0, 0);
      check(0, "t5_next_rxd", rxd_of(0), 32'h5A);
      check(0, "t5_next_miso", got_q[0], 32'hFF);
      idle_load(0, 32'h99);
      check(0, "t5_rdy_before_rst", rdy[0], 1'b0);
      frame(0, 3, -1, 0, 0, 1);

      // Counter saturation with a 2-bit counter.
      frame(0, 48, -1, 0, 0, 0);
      for (int k = 0; k < 6; k++) check(0, $sformatf("t6_cnt%0d", k), cnt_hist[k], exp6[k]);
      check(0, "t6_cnt_after_csn", cnt_of(0), 0);

      // Randomised frames, loads and partial words.
      for (int d = 0; d < 2; d++) begin
         for (int f = 0; f < 30; f++) begin
            nb = dw[d] * int'($urandom_range(1, 4));
            if ($urandom_range(3) == 0) nb += int'($urandom_range(1, dw[d] - 1));
            if ($urandom_range(2) == 0) idle_load(d, $urandom & mask_of(d));
            frame(d, nb, -1, 0, int'($urandom_range(60)), 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
